lfsr_stream: RTL

Parametrised, registered successor to the combinational multi-step LFSR accumulator in the scrambler datapath. Consumes a framed stream of LANE_W-bit beats under valid/ready, advances an STATE_W-bit Galois LFSR one step per input bit, and presents the end-of-frame state with an optional output XOR and a residue-match flag. Sits between the framing logic and the check/insert stage. It adds seed reload per frame, partial final beats, backpressure and sequence-error reporting.

---
 rtl/lfsr_stream_if.sv | 29 ++
 rtl/lfsr_stream.sv | 131 +++++++++++++
 2 files changed

// File: rtl/lfsr_stream_if.sv
// Stream bundle for lfsr_stream: framed beat input, result output and the
// framing-error pulse. The block takes the slave side; the producer and consumer take the master side.
interface lfsr_stream_if #(
  parameter int STATE_W = 84,
  parameter int LANE_W  = 14,
  parameter int NB_W    = $clog2(LANE_W + 1)
);
  logic               in_valid;
  logic               in_ready;
  logic [LANE_W-1:0]  in_data;
  logic               in_sof;
  logic               in_eof;
  logic [NB_W-1:0]    in_nbits;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;
  logic               out_match;
  logic               seq_err;

  modport master (
    output in_valid, in_data, in_sof, in_eof, in_nbits, out_ready,
    input  in_ready, out_valid, out_state, out_match, seq_err
  );

  modport slave (
    input  in_valid, in_data, in_sof, in_eof, in_nbits, out_ready,
    output in_ready, out_valid, out_state, out_match, seq_err
  );
endinterface

// File: rtl/lfsr_stream.sv
// Framed Galois-LFSR accumulator. Each accepted beat advances the state one step
// per valid bit in a single cycle. The end-of-frame state is held until the consumer takes it.

module lfsr_step #(
  parameter int                 STATE_W  = 84,
  parameter logic [STATE_W-1:0] TAP_MASK = '0
) (
  input  logic [STATE_W-1:0] s,
  input  logic               d,
  input  logic               en,
  output logic [STATE_W-1:0] n
);
  logic               m;
  logic [STATE_W-1:0] stepped;

  always_comb begin
    m          = s[STATE_W-1];
    stepped    = '0;
    stepped[0] = m ^ d;
    for (int i = 1; i < STATE_W; i++)
      stepped[i] = s[i-1] ^ (TAP_MASK[i] & m);
    n = en ? stepped : s;
  end
endmodule

module lfsr_stream #(
  parameter int                 STATE_W       = 84,
  parameter int                 LANE_W        = 14,
  parameter logic [STATE_W-1:0] TAP_MASK      = (STATE_W'(1) << 45) | (STATE_W'(1) << 51) |
                                                (STATE_W'(1) << 59),
  parameter logic [STATE_W-1:0] SEED          = '0,
  parameter logic [STATE_W-1:0] XOR_OUT       = '0,
  parameter logic [STATE_W-1:0] CHECK_RESIDUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  lfsr_stream_if.slave io
);
  localparam int NB_W = $clog2(LANE_W + 1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [STATE_W-1:0] lfsr_q, lfsr_d;
  logic [STATE_W-1:0] out_state_q;
  logic               out_match_q;
  logic               seq_err_q, seq_err_d;
  logic               accept;
  logic               done;

  logic [NB_W-1:0]             nbits_eff;
  logic [LANE_W-1:0]           bit_en;
  logic [LANE_W:0][STATE_W-1:0] chain;
  logic [STATE_W-1:0]          upd;

  assign accept = io.in_valid && (fsm_q != HOLD);

  // Out-of-range or zero bit counts on the eof beat mean a full beat.
  always_comb begin
    nbits_eff = NB_W'(LANE_W);
    if (io.in_eof && (io.in_nbits != '0) && (io.in_nbits <= NB_W'(LANE_W)))
      nbits_eff = io.in_nbits;
  end

  // sof always restarts from SEED, which also covers the mid-frame abort case.
  assign chain[0] = io.in_sof ? SEED : lfsr_q;

  for (genvar g = 0; g < LANE_W; g++) begin : g_bit
    assign bit_en[g] = NB_W'(g) < nbits_eff;
    lfsr_step #(.STATE_W(STATE_W), .TAP_MASK(TAP_MASK)) u_step (
      .s  (chain[g]),
      .d  (io.in_data[g]),
      .en (bit_en[g]),
      .n  (chain[g+1])
    );
  end

  assign upd = chain[LANE_W];

  always_comb begin
    fsm_d     = fsm_q;
    lfsr_d    = lfsr_q;
    seq_err_d = 1'b0;
    done      = 1'b0;
    case (fsm_q)
      IDLE: if (accept) begin
        if (io.in_sof) begin
          lfsr_d = upd;
          fsm_d  = io.in_eof ? HOLD : ACC;
          done   = io.in_eof;
        end else begin
          seq_err_d = 1'b1;
        end
      end
      ACC: if (accept) begin
        lfsr_d    = upd;
        seq_err_d = io.in_sof;
        if (io.in_eof) begin
          fsm_d = HOLD;
          done  = 1'b1;
        end
      end
      HOLD: if (io.out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      lfsr_q      <= SEED;
      out_state_q <= '0;
      out_match_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      lfsr_q    <= lfsr_d;
      seq_err_q <= seq_err_d;
      if (done) begin
        out_state_q <= upd ^ XOR_OUT;
        out_match_q <= (upd == CHECK_RESIDUE);
      end
    end
  end

  assign io.in_ready  = (fsm_q != HOLD);
  assign io.out_valid = (fsm_q == HOLD);
  assign io.out_state = out_state_q;
  assign io.out_match = out_match_q;
  assign io.seq_err   = seq_err_q;
endmodule
